pc_flag_ctrl: RTL
=================

PC_FLAG_CTRL -- requirements
Module: pc_flag_ctrl

Interface
REQ-001 Parameter PC_W, default 10, program counter width in bits.
REQ-002 Parameter LUT_DEPTH, default 16, number of branch-target LUT entries.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  single-cycle pulse; begins execution at StartAddr.
REQ-006 StartAddr  input  PC_W  program entry address.
REQ-007 Halt  input  1  decoded halt instruction.
REQ-008 JumpEn  input  1  decoded unconditional jump.
REQ-009 BranchEn  input  1  decoded conditional branch.
REQ-010 BrCond  input  1  branch condition select: 0 = ZERO_FLAG, 1 = SC_FLAG.
REQ-011 Target  input  8  LUT index (bits [3:0]) or signed PC offset, per configuration.
REQ-012 FlagWe  input  1  latch ALU flags this cycle.
REQ-013 ALU_ZERO  input  1  ALU zero output.
REQ-014 ALU_SC  input  1  ALU shift/carry output.
REQ-015 PC  output  PC_W  current instruction address.
REQ-016 Running  output  1  high in RUN state.
REQ-017 Done  output  1  high in HALTED state.
REQ-018 SC_FLAG  output  1  registered carry flag; drives ALU SC_IN.
REQ-019 ZERO_FLAG  output  1  registered zero flag.

Function
REQ-020 FSM states IDLE, RUN, HALTED; all outputs registered, one-cycle latency from decision to PC change.
REQ-021 IDLE: PC holds; Start -> PC=StartAddr, RUN next cycle.
REQ-022 RUN next-PC priority: Start (PC=StartAddr) > Halt (PC holds, go HALTED) > JumpEn (target) > BranchEn taken (target) > PC+1.
REQ-023 Branch taken when BranchEn and selected flag = 1; not-taken -> PC+1.
REQ-024 Branch condition uses flag values registered before the current edge; simultaneous FlagWe affects only later branches.
REQ-025 FlagWe in RUN: SC_FLAG<=ALU_SC, ZERO_FLAG<=ALU_ZERO; FlagWe ignored in IDLE and HALTED and in the cycle Halt is accepted.
REQ-026 PC arithmetic modulo 2^PC_W: PC+1 at all-ones wraps to 0; offset addition wraps identically.
REQ-027 JumpEn and BranchEn together: jump wins.
REQ-028 HALTED: PC and flags hold, Done=1; Start -> PC=StartAddr, Done=0, RUN; flags preserved across restart.
REQ-029 Jump/branch/Halt/FlagWe inputs ignored outside RUN.

Reset
REQ-030 Reset (sync, active-high) overrides all inputs, including Start, in any state, mid-operation included.
REQ-031 Reset values: state IDLE, PC=0, Running=0, Done=0, SC_FLAG=0, ZERO_FLAG=0.
REQ-032 Reset does not clear LUT contents (constant ROM).

Configuration
REQ-033 Macro BRANCH_LUT_EN defined: target = LUT[Target[3:0]] (PC_W-bit absolute address); Target[7:4] ignored.
REQ-034 BRANCH_LUT_EN undefined: target = PC + sign-extended Target (range -128..+127); LUT not instantiated.

Structure
REQ-035 Shared package holds FSM state enum (IDLE/RUN/HALTED), PC_W and LUT_DEPTH defaults, and LUT contents constant array.
REQ-036 Sub-module branch_lut: combinational 4-bit index -> PC_W address ROM, instantiated only under BRANCH_LUT_EN.

Verification
REQ-037 Reset asserted with Start=1 -> next cycle PC=0, IDLE, all flags/status 0.
REQ-038 Start, StartAddr=0x3FE, 3 idle RUN cycles -> PC 0x3FE, 0x3FF, 0x000, 0x001.
REQ-039 PC=0x020, FlagWe with ALU_ZERO=1, next cycle BranchEn BrCond=0 Target=0xFC (no LUT) -> PC=0x01D; same branch issued in FlagWe cycle with old ZERO_FLAG=0 -> PC=0x021.
REQ-040 BRANCH_LUT_EN, LUT[5]=0x100, JumpEn+BranchEn Target=0x05 -> PC=0x100.
REQ-041 Halt at PC=0x042 with FlagWe ALU_SC=1 -> PC holds 0x042, Done=1, SC_FLAG unchanged; Start StartAddr=0x010 -> PC=0x010, Done=0, Running=1.
REQ-042 Reset mid-RUN at PC=0x155 with SC_FLAG=1 -> next cycle PC=0, SC_FLAG=0, IDLE.

Source files
------------

// File: rtl/pc_flag_ctrl_pkg.sv
// Shared types and constants for the program-counter / flag controller.
// The branch-target ROM contents below are only used when BRANCH_LUT_EN is defined.
package pc_flag_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int PC_W_DEF      = 10;
  localparam int LUT_DEPTH_DEF = 16;

  // Absolute branch targets, indexed by Target[3:0]; entry 0 is first.
  localparam logic [PC_W_DEF-1:0] BRANCH_LUT [LUT_DEPTH_DEF] = '{
    10'h000, 10'h011, 10'h022, 10'h033, 10'h044, 10'h100, 10'h1FF, 10'h200,
    10'h2AA, 10'h301, 10'h3FF, 10'h0F0, 10'h155, 10'h07C, 10'h3C0, 10'h01D
  };

endpackage

// File: rtl/pc_flag_ctrl_if.sv
// Decoder-side bus of the PC/flag controller: control inputs in, PC/status/flags out.
interface pc_flag_ctrl_if #(
  parameter int PC_W = 10
);
  logic            Start;
  logic [PC_W-1:0] StartAddr;
  logic            Halt;
  logic            JumpEn;
  logic            BranchEn;
  logic            BrCond;
  logic [7:0]      Target;
  logic            FlagWe;
  logic            ALU_ZERO;
  logic            ALU_SC;
  logic [PC_W-1:0] PC;
  logic            Running;
  logic            Done;
  logic            SC_FLAG;
  logic            ZERO_FLAG;

  modport master (
    output Start, StartAddr, Halt, JumpEn, BranchEn, BrCond, Target,
           FlagWe, ALU_ZERO, ALU_SC,
    input  PC, Running, Done, SC_FLAG, ZERO_FLAG
  );

  modport slave (
    input  Start, StartAddr, Halt, JumpEn, BranchEn, BrCond, Target,
           FlagWe, ALU_ZERO, ALU_SC,
    output PC, Running, Done, SC_FLAG, ZERO_FLAG
  );
endinterface

// File: rtl/pc_flag_ctrl_branch_lut.sv
// Combinational branch-target ROM: 4-bit index to absolute PC address.
// Indices at or beyond LUT_DEPTH read as address zero.
module branch_lut
  import pc_flag_ctrl_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int LUT_DEPTH = LUT_DEPTH_DEF
) (
  input  logic [3:0]      i_idx,
  output logic [PC_W-1:0] o_addr
);

  // ROM lookup with out-of-range guard
  always_comb begin
    o_addr = '0;
    if (32'(i_idx) < LUT_DEPTH) begin
      o_addr = PC_W'(BRANCH_LUT[i_idx]);
    end else begin
      o_addr = '0;
    end
  end

endmodule

// File: rtl/pc_flag_ctrl.sv
// Program counter sequencer with IDLE/RUN/HALTED FSM and registered ALU flags.
// Define BRANCH_LUT_EN for LUT-based absolute targets; default is PC-relative offsets.
module pc_flag_ctrl
  import pc_flag_ctrl_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int LUT_DEPTH = LUT_DEPTH_DEF
) (
  input  logic           CLK,
  input  logic           Reset,
  pc_flag_ctrl_if.slave  bus
);

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_running;
  logic            r_done;
  logic            r_sc;
  logic            r_zero;

  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_pc_inc;
  logic            w_br_flag;
  logic            w_flag_upd;

`ifdef BRANCH_LUT_EN
  branch_lut #(
    .PC_W      (PC_W),
    .LUT_DEPTH (LUT_DEPTH)
  ) u_branch_lut (
    .i_idx  (bus.Target[3:0]),
    .o_addr (w_target)
  );
`else
  assign w_target = r_pc + {{(PC_W-8){bus.Target[7]}}, bus.Target};
`endif

  assign w_pc_inc   = r_pc + PC_W'(1);
  assign w_br_flag  = bus.BrCond ? r_sc : r_zero;
  // A Halt that is actually accepted (no Start outranking it) discards the flag write.
  assign w_flag_upd = bus.FlagWe && (bus.Start || !bus.Halt);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_sc      <= 1'b0;
      r_zero    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, HALTED: begin
          if (bus.Start) begin
            r_pc      <= bus.StartAddr;
            r_state   <= RUN;
            r_running <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        RUN: begin
          if (w_flag_upd) begin
            r_sc   <= bus.ALU_SC;
            r_zero <= bus.ALU_ZERO;
          end
          if (bus.Start) begin
            r_pc <= bus.StartAddr;
          end else if (bus.Halt) begin
            r_state   <= HALTED;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end else if (bus.JumpEn) begin
            r_pc <= w_target;
          end else if (bus.BranchEn && w_br_flag) begin
            r_pc <= w_target;
          end else begin
            r_pc <= w_pc_inc;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_pc      <= '0;
          r_running <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PC        = r_pc;
  assign bus.Running   = r_running;
  assign bus.Done      = r_done;
  assign bus.SC_FLAG   = r_sc;
  assign bus.ZERO_FLAG = r_zero;

endmodule
